// File: rtl/if_id_queue.sv
// if_id_queue: pairs PC addresses with synchronous-ROM data and queues {pc, inst} entries for decode
module if_id_queue #(
  parameter int INST_ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [INST_ADDR_WIDTH-1:0] pc_addr,
  input  logic                       pc_enable,
  input  logic [INST_WIDTH-1:0]      rom_data,
  input  logic                       flush,
  input  logic                       id_ready,
  output logic                       fetch_stall,
  output logic                       id_valid,
  output logic [INST_ADDR_WIDTH-1:0] id_pc,
  output logic [INST_WIDTH-1:0]      id_inst,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic                       req_valid;
  logic [INST_ADDR_WIDTH-1:0] req_pc;
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic [INST_ADDR_WIDTH-1:0] mem_pc [DEPTH];
  logic [INST_WIDTH-1:0]      mem_inst [DEPTH];
  logic                       push, pop;
  logic [AW+1:0]              occ;
  // occupancy counts the in-flight request so it always finds a free slot next cycle
  assign occ         = {1'b0, count} + (AW+2)'(req_valid);
  assign fetch_stall = occ >= (AW+2)'(DEPTH);
  assign id_valid    = count != '0;
  assign push        = req_valid & ~flush;
  assign pop         = id_valid & id_ready & ~flush;
  assign id_pc       = mem_pc[rd_ptr];
  assign id_inst     = mem_inst[rd_ptr];
  // request register, pointers and occupancy; flush wipes queue and in-flight request
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      req_valid <= 1'b0;
      req_pc    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else if (flush) begin
      req_valid <= 1'b0;
      req_pc    <= pc_addr;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      req_valid <= pc_enable & ~fetch_stall;
      req_pc    <= pc_addr;
      wr_ptr    <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr    <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count     <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // entry storage pairs the registered address with the ROM word returned for it
  always_ff @(posedge clk)
    if (push) begin
      mem_pc[wr_ptr]   <= req_pc;
      mem_inst[wr_ptr] <= rom_data;
    end
  // stall logic must make a push into a full queue unreachable
  always_ff @(posedge clk)
    if (rst_n && push && !pop) assert (int'(count) < DEPTH);
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: random/directed stimulus checked against a queue-based model of the fetch queue
module tb_if_id_queue;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_addr = '0;
  logic        pc_enable = 1'b0;
  logic [31:0] rom_data = '0;
  logic        flush = 1'b0;
  logic        id_ready = 1'b0;
  logic        fetch_stall, id_valid;
  logic [31:0] id_pc, id_inst;
  logic [2:0]  count;
  logic [31:0] q_pc[$];
  logic [31:0] q_inst[$];
  bit          inf_v = 1'b0;
  logic [31:0] inf_pc = '0;
  logic [31:0] prev_pc = '0;
  int          n_chk = 0;
  int          n_fail = 0;

  if_id_queue dut (
    .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr), .pc_enable(pc_enable),
    .rom_data(rom_data), .flush(flush), .id_ready(id_ready),
    .fetch_stall(fetch_stall), .id_valid(id_valid), .id_pc(id_pc),
    .id_inst(id_inst), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock cycle: drive inputs, check outputs at negedge, advance model at posedge
  task automatic cycle(input bit en, input bit rdy, input bit fl);
    bit exp_stall;
    pc_enable = en;
    id_ready  = rdy;
    flush     = fl;
    rom_data  = prev_pc + 32'h1000;
    @(negedge clk);
    exp_stall = (q_pc.size() + int'(inf_v)) >= 4;
    chk("count", 64'(count), 64'(q_pc.size()));
    chk("id_valid", 64'(id_valid), 64'(q_pc.size() != 0));
    chk("fetch_stall", 64'(fetch_stall), 64'(exp_stall));
    if (q_pc.size() != 0) begin
      chk("id_pc", 64'(id_pc), 64'(q_pc[0]));
      chk("id_inst", 64'(id_inst), 64'(q_inst[0]));
    end
    if (fl) begin
      q_pc.delete();
      q_inst.delete();
      inf_v = 1'b0;
    end else begin
      if (q_pc.size() != 0 && rdy) begin
        void'(q_pc.pop_front());
        void'(q_inst.pop_front());
      end
      if (inf_v) begin
        q_pc.push_back(inf_pc);
        q_inst.push_back(inf_pc + 32'h1000);
      end
      inf_v  = en && !exp_stall;
      inf_pc = pc_addr;
    end
    @(posedge clk);
    #1;
    prev_pc = pc_addr;
    if (en && !exp_stall && !fl) pc_addr = pc_addr + 32'd4;
  endtask

  initial begin
    int guard;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_stall", 64'(fetch_stall), 64'd0);
    rst_n = 1'b1;
    // streaming with decode always ready
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0);
    // back-pressure then drain
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0);
    // alternate ready across several pointer wraps
    for (int i = 0; i < 40; i++) cycle(1'b1, i[0], 1'b0);
    // flush with three entries queued and one request in flight
    guard = 0;
    while (!(q_pc.size() == 3 && inf_v) && guard < 20) begin
      cycle(1'b1, 1'b0, 1'b0);
      guard++;
    end
    chk("flush_setup", 64'(q_pc.size() == 3 && inf_v), 64'd1);
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0);
    // asynchronous reset mid-cycle with two entries queued
    guard = 0;
    while (q_pc.size() != 2 && guard < 20) begin
      cycle(1'b1, 1'b0, 1'b0);
      guard++;
    end
    chk("reset_setup", 64'(q_pc.size()), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_id_valid", 64'(id_valid), 64'd0);
    chk("arst_stall", 64'(fetch_stall), 64'd0);
    q_pc.delete();
    q_inst.delete();
    inf_v = 1'b0;
    @(posedge clk);
    #1;
    pc_addr = '0;
    prev_pc = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0);
    // random traffic with occasional flushes and PC pauses
    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 30) == 0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
